// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and the squaring helper for the FFT
// post-processing blocks.
package fft_pkg;

  localparam int DATA_W   = 14;
  localparam int FFT_PTS  = 1024;
  localparam int BIN_W    = 10;
  localparam int PWR_W    = 2 * DATA_W;
  // Wrapper-side fft_pts width: wide enough to hold FFT_PTS itself.
  localparam int FFTPTS_W = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Square is non-negative and at most 2^26, so the low PWR_W bits are exact.
  function automatic logic signed [PWR_W-1:0] square(input logic signed [DATA_W-1:0] x);
    logic signed [PWR_W-1:0] xe;
    xe = PWR_W'(x);
    return xe * xe;
  endfunction

endpackage

// File: rtl/fft_power_calc.sv
// Two-stage squared-magnitude pipeline: products in S1, sum in S2, with the
// beat's bin/sop/eop tags carried alongside.
module fft_power_calc
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic                     sop_i,
  input  logic                     eop_i,
  input  logic [BIN_W-1:0]         bin_i,
  input  logic signed [DATA_W-1:0] real_i,
  input  logic signed [DATA_W-1:0] imag_i,
  output logic                     valid_o,
  output logic                     sop_o,
  output logic                     eop_o,
  output logic [BIN_W-1:0]         bin_o,
  output logic [PWR_W-1:0]         pwr_o
);

  logic                    v1_q, sop1_q, eop1_q;
  logic [BIN_W-1:0]        bin1_q;
  logic signed [PWR_W-1:0] re_sq_q, im_sq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sop1_q  <= 1'b0;
      eop1_q  <= 1'b0;
      bin1_q  <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
      bin_o   <= '0;
      pwr_o   <= '0;
    end else begin
      v1_q    <= valid_i;
      sop1_q  <= valid_i & sop_i;
      eop1_q  <= valid_i & eop_i;
      bin1_q  <= bin_i;
      re_sq_q <= square(real_i);
      im_sq_q <= square(imag_i);
      valid_o <= v1_q;
      sop_o   <= sop1_q;
      eop_o   <= eop1_q;
      bin_o   <= bin1_q;
      pwr_o   <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Framing FSM, bin counter and windowed peak tracker behind the FFT source
// stream; emits per-bin power and one peak report per good frame.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     src_valid,
  input  logic                     src_sop,
  input  logic                     src_eop,
  input  logic signed [DATA_W-1:0] src_real,
  input  logic signed [DATA_W-1:0] src_imag,
  output logic                     pwr_valid,
  output logic [BIN_W-1:0]         pwr_bin,
  output logic [PWR_W-1:0]         pwr_data,
  output logic                     peak_valid,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [PWR_W-1:0]         peak_pwr,
  output logic                     frame_err
);

  localparam logic [BIN_W-1:0]    BIN_LO_V = BIN_LO[BIN_W-1:0];
  localparam logic [BIN_W-1:0]    BIN_HI_V = BIN_HI[BIN_W-1:0];
  localparam logic [FFTPTS_W-1:0] LAST_CNT = FFTPTS_W'(FFT_PTS - 1);
  localparam logic [FFTPTS_W-1:0] FULL_CNT = FFTPTS_W'(FFT_PTS);

  state_t              state_q, state_d;
  logic [FFTPTS_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                acc_v, acc_sop, acc_last;
  logic [BIN_W-1:0]    acc_bin;
  logic                cnt_full;

  // cnt_q == FFT_PTS means the last bin went by without eop.
  assign cnt_full = (cnt_q == FULL_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (src_valid) begin
      if (src_sop)
        state_d = src_eop ? IDLE : FRAME;
      else if (state_q == FRAME && (src_eop || cnt_full))
        state_d = IDLE;
    end
  end

  always_comb begin
    acc_v    = 1'b0;
    acc_sop  = 1'b0;
    acc_last = 1'b0;
    acc_bin  = '0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    if (src_valid) begin
      if (src_sop) begin
        // A sop always (re)starts a frame as bin 0; mid-frame it is also an error.
        acc_v   = 1'b1;
        acc_sop = 1'b1;
        err_d   = (state_q == FRAME);
        cnt_d   = FFTPTS_W'(1);
        if (src_eop) begin
          cnt_d = '0;
          if (LAST_CNT == '0) acc_last = 1'b1;
          else                err_d    = 1'b1;
        end
      end else if (state_q == FRAME) begin
        if (cnt_full) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          acc_v   = 1'b1;
          acc_bin = cnt_q[BIN_W-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (src_eop) begin
            cnt_d = '0;
            if (cnt_q == LAST_CNT) acc_last = 1'b1;
            else                   err_d    = 1'b1;
          end
        end
      end else if (src_eop) begin
        err_d = 1'b1;
      end
    end
  end

  logic pwr_sop, pwr_last;

  fft_power_calc u_power (
    .clk     (clk),
    .reset   (reset),
    .valid_i (acc_v),
    .sop_i   (acc_sop),
    .eop_i   (acc_last),
    .bin_i   (acc_bin),
    .real_i  (src_real),
    .imag_i  (src_imag),
    .valid_o (pwr_valid),
    .sop_o   (pwr_sop),
    .eop_o   (pwr_last),
    .bin_o   (pwr_bin),
    .pwr_o   (pwr_data)
  );

  logic [PWR_W-1:0] best_pwr_q, base_pwr, cand_pwr, peak_pwr_q;
  logic [BIN_W-1:0] best_bin_q, base_bin, cand_bin, peak_bin_q;
  logic             peak_valid_q;

  // Bin 0 starts from a cleared best; strict compare keeps the lowest bin on ties.
  always_comb begin
    base_pwr = pwr_sop ? '0 : best_pwr_q;
    base_bin = pwr_sop ? BIN_LO_V : best_bin_q;
    cand_pwr = base_pwr;
    cand_bin = base_bin;
    if (pwr_bin >= BIN_LO_V && pwr_bin <= BIN_HI_V && pwr_data > base_pwr) begin
      cand_pwr = pwr_data;
      cand_bin = pwr_bin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_pwr_q   <= '0;
      best_bin_q   <= '0;
      peak_valid_q <= 1'b0;
      peak_pwr_q   <= '0;
      peak_bin_q   <= '0;
    end else begin
      peak_valid_q <= 1'b0;
      if (pwr_valid) begin
        best_pwr_q <= cand_pwr;
        best_bin_q <= cand_bin;
        if (pwr_last) begin
          peak_valid_q <= 1'b1;
          peak_pwr_q   <= cand_pwr;
          peak_bin_q   <= cand_bin;
        end
      end
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_pwr   = peak_pwr_q;
  assign frame_err  = err_q;

endmodule
